// File: rtl/seq_alu.sv
// seq_alu: sequential ALU with one-cycle ADD/SUB/logic ops and bit-serial unsigned MUL/DIV.
// Build macro SEQ_ALU_DIV_EN enables the restoring divider; without it op 111 reports err.
module seq_alu #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             carry,
  output logic             zero,
  output logic             negative,
  output logic             overflow,
  output logic             err
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_NOT = 3'b101;
  localparam logic [2:0] OP_MUL = 3'b110;
  localparam logic [2:0] OP_DIV = 3'b111;

  localparam int            CW        = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  // Explicit ripple carry chain shared by ADD and SUB.
  function automatic logic [WIDTH:0] ripple_add(input logic [WIDTH-1:0] x,
                                                input logic [WIDTH-1:0] y,
                                                input logic             cin);
    logic [WIDTH-1:0] s;
    logic             c;
    s = {WIDTH{1'b0}};
    c = cin;
    for (int i = 0; i < WIDTH; i++) begin
      s[i] = x[i] ^ y[i] ^ c;
      c    = (x[i] & y[i]) | (c & (x[i] ^ y[i]));
    end
    return {c, s};
  endfunction

  logic [1:0]       state_r, state_s;
  logic             in_ready_r, in_ready_s;
  logic             out_valid_r, out_valid_s;
  logic [WIDTH-1:0] result_r, result_s;
  logic [WIDTH-1:0] result_hi_r, result_hi_s;
  logic             carry_r, carry_s;
  logic             zero_r, zero_s;
  logic             negative_r, negative_s;
  logic             overflow_r, overflow_s;
  logic             err_r, err_s;
  logic [WIDTH-1:0] acc_r, acc_s;
  logic [WIDTH-1:0] lo_r, lo_s;
  logic [WIDTH-1:0] opd_r, opd_s;
  logic [CW-1:0]    cnt_r, cnt_s;
  logic             is_div_r, is_div_s;

  logic             is_sub_s;
  logic [WIDTH-1:0] addend_s;
  logic [WIDTH:0]   add_s;
  logic [WIDTH-1:0] alu_lo_s;
  logic [WIDTH-1:0] alu_hi_s;
  logic             alu_c_s;
  logic             alu_v_s;
  logic             alu_err_s;
  logic             go_busy_s;
  logic [WIDTH:0]   mul_sum_s;
  logic [WIDTH-1:0] step_acc_s;
  logic [WIDTH-1:0] step_lo_s;
  logic             step_hi_nz_s;
`ifdef SEQ_ALU_DIV_EN
  logic [WIDTH:0]   div_shift_s;
  logic [WIDTH-1:0] div_diff_s;
`endif

  // Single-cycle results computed straight from the request inputs.
  always_comb begin
    is_sub_s  = (op == OP_SUB);
    addend_s  = is_sub_s ? ~b : b;
    add_s     = ripple_add(a, addend_s, is_sub_s);
    alu_lo_s  = {WIDTH{1'b0}};
    alu_hi_s  = {WIDTH{1'b0}};
    alu_c_s   = 1'b0;
    alu_v_s   = 1'b0;
    alu_err_s = 1'b0;
    case (op)
      OP_ADD, OP_SUB: begin
        alu_lo_s = add_s[WIDTH-1:0];
        // carry-out of a + ~b + 1 is the inverse of borrow
        alu_c_s  = add_s[WIDTH] ^ is_sub_s;
        alu_v_s  = (a[WIDTH-1] == addend_s[WIDTH-1]) && (add_s[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND: alu_lo_s = a & b;
      OP_OR:  alu_lo_s = a | b;
      OP_XOR: alu_lo_s = a ^ b;
      OP_NOT: alu_lo_s = ~a;
      OP_MUL: alu_lo_s = {WIDTH{1'b0}};
      OP_DIV: begin
`ifdef SEQ_ALU_DIV_EN
        alu_lo_s  = {WIDTH{1'b1}};
        alu_hi_s  = a;
`endif
        alu_err_s = 1'b1;
      end
      default: alu_lo_s = {WIDTH{1'b0}};
    endcase
`ifdef SEQ_ALU_DIV_EN
    go_busy_s = (op == OP_MUL) || ((op == OP_DIV) && (b != {WIDTH{1'b0}}));
`else
    go_busy_s = (op == OP_MUL);
`endif
  end

  // One iteration of the shift-add multiplier or the restoring divider.
  always_comb begin
    mul_sum_s = {1'b0, acc_r} + (lo_r[0] ? {1'b0, opd_r} : {(WIDTH+1){1'b0}});
`ifdef SEQ_ALU_DIV_EN
    div_shift_s = {acc_r, lo_r[WIDTH-1]};
    div_diff_s  = div_shift_s[WIDTH-1:0] - opd_r;
    if (is_div_r) begin
      if (div_shift_s >= {1'b0, opd_r}) begin
        step_acc_s = div_diff_s;
        step_lo_s  = {lo_r[WIDTH-2:0], 1'b1};
      end else begin
        step_acc_s = div_shift_s[WIDTH-1:0];
        step_lo_s  = {lo_r[WIDTH-2:0], 1'b0};
      end
    end else begin
      step_acc_s = mul_sum_s[WIDTH:1];
      step_lo_s  = {mul_sum_s[0], lo_r[WIDTH-1:1]};
    end
`else
    step_acc_s = mul_sum_s[WIDTH:1];
    step_lo_s  = {mul_sum_s[0], lo_r[WIDTH-1:1]};
`endif
    step_hi_nz_s = !is_div_r && (step_acc_s != {WIDTH{1'b0}});
  end

  // Next-state and next output-register values for the valid/ready handshake.
  always_comb begin
    state_s     = state_r;
    out_valid_s = out_valid_r;
    result_s    = result_r;
    result_hi_s = result_hi_r;
    carry_s     = carry_r;
    zero_s      = zero_r;
    negative_s  = negative_r;
    overflow_s  = overflow_r;
    err_s       = err_r;
    acc_s       = acc_r;
    lo_s        = lo_r;
    opd_s       = opd_r;
    cnt_s       = cnt_r;
    is_div_s    = is_div_r;
    case (state_r)
      IDLE: begin
        if (in_valid && in_ready_r) begin
          is_div_s = (op == OP_DIV);
          cnt_s    = {CW{1'b0}};
          if (go_busy_s) begin
            // MUL shifts the multiplier through lo; DIV shifts the dividend through it
            state_s = BUSY;
            acc_s   = {WIDTH{1'b0}};
            lo_s    = (op == OP_MUL) ? b : a;
            opd_s   = (op == OP_MUL) ? a : b;
          end else begin
            state_s     = DONE;
            out_valid_s = 1'b1;
            result_s    = alu_lo_s;
            result_hi_s = alu_hi_s;
            carry_s     = alu_c_s;
            zero_s      = (alu_lo_s == {WIDTH{1'b0}});
            negative_s  = alu_lo_s[WIDTH-1];
            overflow_s  = alu_v_s;
            err_s       = alu_err_s;
          end
        end else begin
          out_valid_s = 1'b0;
        end
      end
      BUSY: begin
        acc_s = step_acc_s;
        lo_s  = step_lo_s;
        if (cnt_r == LAST_STEP) begin
          state_s     = DONE;
          out_valid_s = 1'b1;
          result_s    = step_lo_s;
          result_hi_s = step_acc_s;
          carry_s     = step_hi_nz_s;
          zero_s      = (step_lo_s == {WIDTH{1'b0}});
          negative_s  = step_lo_s[WIDTH-1];
          overflow_s  = step_hi_nz_s;
          err_s       = 1'b0;
        end else begin
          cnt_s = cnt_r + CW'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          state_s     = IDLE;
          out_valid_s = 1'b0;
        end else begin
          state_s = DONE;
        end
      end
      default: begin
        state_s     = IDLE;
        out_valid_s = 1'b0;
      end
    endcase
    in_ready_s = (state_s == IDLE);
  end

  // State and output registers; reset clears everything including in_ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      in_ready_r  <= 1'b0;
      out_valid_r <= 1'b0;
      result_r    <= {WIDTH{1'b0}};
      result_hi_r <= {WIDTH{1'b0}};
      carry_r     <= 1'b0;
      zero_r      <= 1'b0;
      negative_r  <= 1'b0;
      overflow_r  <= 1'b0;
      err_r       <= 1'b0;
      acc_r       <= {WIDTH{1'b0}};
      lo_r        <= {WIDTH{1'b0}};
      opd_r       <= {WIDTH{1'b0}};
      cnt_r       <= {CW{1'b0}};
      is_div_r    <= 1'b0;
    end else begin
      state_r     <= state_s;
      in_ready_r  <= in_ready_s;
      out_valid_r <= out_valid_s;
      result_r    <= result_s;
      result_hi_r <= result_hi_s;
      carry_r     <= carry_s;
      zero_r      <= zero_s;
      negative_r  <= negative_s;
      overflow_r  <= overflow_s;
      err_r       <= err_s;
      acc_r       <= acc_s;
      lo_r        <= lo_s;
      opd_r       <= opd_s;
      cnt_r       <= cnt_s;
      is_div_r    <= is_div_s;
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign result    = result_r;
  assign result_hi = result_hi_r;
  assign carry     = carry_r;
  assign zero      = zero_r;
  assign negative  = negative_r;
  assign overflow  = overflow_r;
  assign err       = err_r;

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu (WIDTH=8): directed, random, hold, throughput and reset scenarios.
module tb_seq_alu;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] op;
  logic [7:0] a;
  logic [7:0] b;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] result;
  logic [7:0] result_hi;
  logic       carry;
  logic       zero;
  logic       negative;
  logic       overflow;
  logic       err;

  int total;
  int bad;

  seq_alu #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .op(op), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready), .result(result), .result_hi(result_hi),
    .carry(carry), .zero(zero), .negative(negative), .overflow(overflow), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: {hi, lo, carry, zero, negative, overflow, err} from plain integer arithmetic.
  function automatic logic [20:0] ref_model(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y);
    int ux, uy, sx, sy, r, sr;
    logic [7:0] lo, hi;
    logic c, v, e;
    ux = int'(x); uy = int'(y); sx = int'($signed(x)); sy = int'($signed(y));
    lo = 8'h00; hi = 8'h00; c = 1'b0; v = 1'b0; e = 1'b0;
    case (o)
      3'd0: begin r = ux + uy; sr = sx + sy; lo = 8'(r); c = (r > 255); v = (sr > 127) || (sr < -128); end
      3'd1: begin r = ux - uy; sr = sx - sy; lo = 8'(r); c = (ux < uy); v = (sr > 127) || (sr < -128); end
      3'd2: lo = x & y;
      3'd3: lo = x | y;
      3'd4: lo = x ^ y;
      3'd5: lo = ~x;
      3'd6: begin r = ux * uy; lo = 8'(r % 256); hi = 8'(r / 256); c = (hi != 8'h00); v = c; end
      default: begin
`ifdef SEQ_ALU_DIV_EN
        if (uy == 0) begin lo = 8'hFF; hi = x; e = 1'b1; end
        else begin lo = 8'(ux / uy); hi = 8'(ux % uy); end
`else
        e = 1'b1;
`endif
      end
    endcase
    return {hi, lo, c, (lo == 8'h00), lo[7], v, e};
  endfunction

  function automatic int ref_lat(input logic [2:0] o, input logic [7:0] y);
    if (o == 3'd6) return 9;
`ifdef SEQ_ALU_DIV_EN
    if (o == 3'd7 && y != 8'h00) return 9;
`endif
    return 1;
  endfunction

  // Issue one request; report latency (accept edge counts as 1), outputs and any in_ready while pending.
  task automatic run_op(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y,
                        output int lat, output logic [20:0] obs, output logic rdy_seen);
    int guard;
    guard = 0;
    rdy_seen = 1'b0;
    @(negedge clk);
    while (!in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    in_valid = 1'b1; op = o; a = x; b = y;
    @(posedge clk); #1;
    in_valid = 1'b0; op = 3'($urandom); a = 8'($urandom); b = 8'($urandom);
    lat = 1;
    while (!out_valid && lat < 40) begin
      if (in_ready) rdy_seen = 1'b1;
      @(posedge clk); #1;
      lat++;
    end
    if (in_ready) rdy_seen = 1'b1;
    obs = {result_hi, result, carry, zero, negative, overflow, err};
  endtask

  task automatic release_out(output logic [1:0] st);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    st = {in_ready, out_valid};
  endtask

  task automatic test_reset;
    logic [22:0] obs;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    obs = {in_ready, out_valid, result_hi, result, carry, zero, negative, overflow, err};
    total++;
    if (obs !== 23'd0) begin bad++; $display("FAIL reset_outputs: got %h want 0", obs); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    total++;
    if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_ready_before_edge: got %b want 0", in_ready); end
    @(posedge clk); #1;
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_ready_after_edge: got %b want 1", in_ready); end
  endtask

  task automatic test_directed;
    logic [2:0]  d_op  [6];
    logic [7:0]  d_a   [6];
    logic [7:0]  d_b   [6];
    logic [20:0] d_exp [6];
    int          d_lat [6];
    int lat;
    logic [20:0] obs;
    logic rdy;
    logic [1:0] st;
    d_op[0] = 3'd0; d_a[0] = 8'hFF; d_b[0] = 8'h01; d_exp[0] = {8'h00, 8'h00, 5'b11000}; d_lat[0] = 1;
    d_op[1] = 3'd1; d_a[1] = 8'h80; d_b[1] = 8'h01; d_exp[1] = {8'h00, 8'h7F, 5'b00010}; d_lat[1] = 1;
    d_op[2] = 3'd1; d_a[2] = 8'h01; d_b[2] = 8'h02; d_exp[2] = {8'h00, 8'hFF, 5'b10100}; d_lat[2] = 1;
    d_op[3] = 3'd6; d_a[3] = 8'hFF; d_b[3] = 8'hFF; d_exp[3] = {8'hFE, 8'h01, 5'b10010}; d_lat[3] = 9;
    d_op[4] = 3'd7; d_a[4] = 8'hC8; d_b[4] = 8'h07;
    d_op[5] = 3'd7; d_a[5] = 8'h5A; d_b[5] = 8'h00;
`ifdef SEQ_ALU_DIV_EN
    d_exp[4] = {8'h04, 8'h1C, 5'b00000}; d_lat[4] = 9;
    d_exp[5] = {8'h5A, 8'hFF, 5'b00101}; d_lat[5] = 1;
`else
    d_exp[4] = {8'h00, 8'h00, 5'b01001}; d_lat[4] = 1;
    d_exp[5] = {8'h00, 8'h00, 5'b01001}; d_lat[5] = 1;
`endif
    for (int i = 0; i < 6; i++) begin
      run_op(d_op[i], d_a[i], d_b[i], lat, obs, rdy);
      total++;
      if (obs !== d_exp[i]) begin bad++; $display("FAIL directed_%0d_value: got %h want %h", i, obs, d_exp[i]); end
      total++;
      if (lat !== d_lat[i]) begin bad++; $display("FAIL directed_%0d_latency: got %0d want %0d", i, lat, d_lat[i]); end
      total++;
      if (rdy !== 1'b0) begin bad++; $display("FAIL directed_%0d_ready_while_pending: got %b want 0", i, rdy); end
      release_out(st);
      total++;
      if (st !== 2'b10) begin bad++; $display("FAIL directed_%0d_release: got %b want 10", i, st); end
    end
  endtask

  task automatic test_random;
    logic [2:0] o;
    logic [7:0] x, y;
    logic [20:0] obs, exp;
    int lat;
    logic rdy;
    logic [1:0] st;
    for (int i = 0; i < 40; i++) begin
      o = 3'($urandom_range(0, 7));
      x = 8'($urandom);
      y = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      exp = ref_model(o, x, y);
      run_op(o, x, y, lat, obs, rdy);
      total++;
      if (obs !== exp) begin bad++; $display("FAIL random_%0d_value op=%0d a=%h b=%h: got %h want %h", i, o, x, y, obs, exp); end
      total++;
      if (lat !== ref_lat(o, y)) begin bad++; $display("FAIL random_%0d_latency op=%0d: got %0d want %0d", i, o, lat, ref_lat(o, y)); end
      total++;
      if (rdy !== 1'b0) begin bad++; $display("FAIL random_%0d_ready_while_pending: got %b want 0", i, rdy); end
      release_out(st);
      total++;
      if (st !== 2'b10) begin bad++; $display("FAIL random_%0d_release: got %b want 10", i, st); end
    end
  endtask

  task automatic test_hold;
    logic [7:0] x, y;
    logic [20:0] obs, exp;
    logic [22:0] cur;
    int lat;
    logic rdy;
    logic [1:0] st;
    x = 8'($urandom); y = 8'($urandom);
    exp = ref_model(3'd4, x, y);
    run_op(3'd4, x, y, lat, obs, rdy);
    total++;
    if (obs !== exp) begin bad++; $display("FAIL hold_value: got %h want %h", obs, exp); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      cur = {in_ready, out_valid, result_hi, result, carry, zero, negative, overflow, err};
      total++;
      if (cur !== {2'b01, exp}) begin bad++; $display("FAIL hold_stable_%0d: got %h want %h", i, cur, {2'b01, exp}); end
    end
    release_out(st);
    total++;
    if (st !== 2'b10) begin bad++; $display("FAIL hold_release: got %b want 10", st); end
  endtask

  task automatic test_back_to_back;
    logic [20:0] q[$];
    logic [20:0] exp, obs;
    logic [2:0] o;
    logic [7:0] x, y;
    int accepts;
    accepts = 0;
    @(negedge clk);
    out_ready = 1'b1;
    in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (out_valid) begin
        obs = {result_hi, result, carry, zero, negative, overflow, err};
        total++;
        if (q.size() == 0) begin bad++; $display("FAIL b2b_unexpected_result: got %h want none", obs); end
        else begin
          exp = q.pop_front();
          if (obs !== exp) begin bad++; $display("FAIL b2b_value_%0d: got %h want %h", i, obs, exp); end
        end
      end
      o = 3'($urandom_range(0, 5)); x = 8'($urandom); y = 8'($urandom);
      op = o; a = x; b = y;
      if (in_ready) begin
        q.push_back(ref_model(o, x, y));
        accepts++;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    total++;
    if (accepts !== 10) begin bad++; $display("FAIL b2b_throughput: got %0d accepts want 10", accepts); end
  endtask

  task automatic test_reset_mid_mul;
    logic [22:0] obs;
    logic seen;
    @(negedge clk);
    in_valid = 1'b1; op = 3'd6; a = 8'($urandom_range(1, 255)); b = 8'($urandom_range(1, 255));
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    obs = {in_ready, out_valid, result_hi, result, carry, zero, negative, overflow, err};
    total++;
    if (obs !== 23'd0) begin bad++; $display("FAIL midmul_reset_outputs: got %h want 0", obs); end
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL midmul_ready_after_release: got %b want 1", in_ready); end
    seen = 1'b0;
    repeat (12) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    total++;
    if (seen !== 1'b0) begin bad++; $display("FAIL midmul_aborted_result: got out_valid %b want 0", seen); end
  endtask

  initial begin
    total = 0;
    bad = 0;
    rst_n = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    op = 3'd0;
    a = 8'h00;
    b = 8'h00;
    test_reset;
    test_directed;
    test_random;
    test_hold;
    test_back_to_back;
    test_reset_mid_mul;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation still running at time limit, want completion");
    $fatal(1, "time limit");
  end

endmodule
